// File: rtl/bus_decode_if.sv
// CPU-side bus bundle for the address decoder: 68030 cycle inputs plus
// the registered selects, bus error and overlay status it returns.
interface bus_decode_if;
  logic [31:0] ADDR;
  logic [2:0]  FC;
  logic        RnW;
  logic        nAS;
  logic        nDSACK0;
  logic        nDSACK1;
  logic        nDRAM_CS;
  logic        nROM_CS;
  logic        nIO_CS;
  logic        nBERR;
  logic        OVERLAY;

  modport master (
    output ADDR, FC, RnW, nAS, nDSACK0, nDSACK1,
    input  nDRAM_CS, nROM_CS, nIO_CS, nBERR, OVERLAY
  );

  modport slave (
    input  ADDR, FC, RnW, nAS, nDSACK0, nDSACK1,
    output nDRAM_CS, nROM_CS, nIO_CS, nBERR, OVERLAY
  );
endinterface

// File: rtl/bus_decode.sv
// Playground 68030 address decoder: registered DRAM/ROM/IO selects, boot
// ROM overlay at address 0, and bus error on unmapped or unterminated cycles.
module bus_decode #(
  parameter int DRAM_SIZE_LOG2 = 28,
  parameter int TIMEOUT_CYCLES = 250
) (
  input logic         CLK,
  input logic         nRST,
  bus_decode_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] BERR   = 2'd3;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [9:0] cnt;
  logic       dram_cs_n, rom_cs_n, io_cs_n, berr_n, overlay;

  logic cpu_space, dram_hit, io_hit, rom_hit;
  logic sel_dram, sel_rom, sel_io, unmapped;
  logic dsack;

  always_comb begin
    cpu_space = (bus.FC == 3'b111);
    dram_hit  = ((bus.ADDR >> DRAM_SIZE_LOG2) == 32'd0);
    io_hit    = (bus.ADDR[31:24] == 8'hFE);
    rom_hit   = (bus.ADDR[31:24] == 8'hFF);
    // Overlay redirects DRAM-window reads to ROM; writes still reach DRAM.
    sel_dram  = !cpu_space && dram_hit && !(overlay && bus.RnW);
    sel_rom   = !cpu_space && (rom_hit || (dram_hit && overlay && bus.RnW));
    sel_io    = !cpu_space && io_hit;
    unmapped  = !cpu_space && !(dram_hit || io_hit || rom_hit);
    dsack     = !bus.nDSACK0 || !bus.nDSACK1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      dram_cs_n <= 1'b1;
      rom_cs_n  <= 1'b1;
      io_cs_n   <= 1'b1;
      berr_n    <= 1'b1;
      overlay   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.nAS) begin
            if (unmapped) begin
              berr_n <= 1'b0;
              state  <= BERR;
            end else begin
              // CPU-space cycles land here with no select, so the watchdog still runs.
              dram_cs_n <= !sel_dram;
              rom_cs_n  <= !sel_rom;
              io_cs_n   <= !sel_io;
              cnt       <= '0;
              state     <= ACTIVE;
              if (sel_rom && rom_hit) overlay <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          // nAS release beats DSACK, and DSACK beats a same-edge timeout.
          if (bus.nAS) begin
            dram_cs_n <= 1'b1;
            rom_cs_n  <= 1'b1;
            io_cs_n   <= 1'b1;
            state     <= IDLE;
          end else if (dsack) begin
            state <= DONE;
          end else if (cnt == TMO_LAST) begin
            berr_n <= 1'b0;
            state  <= BERR;
          end else if (cnt != '1) begin
            cnt <= cnt + 10'd1;
          end
        end
        DONE, BERR: begin
          if (bus.nAS) begin
            dram_cs_n <= 1'b1;
            rom_cs_n  <= 1'b1;
            io_cs_n   <= 1'b1;
            berr_n    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.nDRAM_CS = dram_cs_n;
  assign bus.nROM_CS  = rom_cs_n;
  assign bus.nIO_CS   = io_cs_n;
  assign bus.nBERR    = berr_n;
  assign bus.OVERLAY  = overlay;

endmodule

// File: doc/bus_decode.md
# bus_decode

Address decoder and bus-cycle watchdog for the Playground 68030, directly upstream of the DRAM controller. It samples each CPU bus cycle and produces registered active-low chip selects for DRAM, ROM and I/O. It maintains the boot-time ROM overlay at address 0, and asserts bus error on unmapped accesses or on cycles that no slave terminates within a timeout.

## Interface
Parameters:
- DRAM_SIZE_LOG2, 28: log2 of the DRAM window size in bytes. DRAM occupies 0 to 2^DRAM_SIZE_LOG2-1.
- TIMEOUT_CYCLES, 250: CLK cycles from cycle start to watchdog bus error (10 us at 25 MHz). Must be 2 to 1023.

Ports:
- CLK, in, 1: system clock, 25 MHz.
- nRST, in, 1: asynchronous active-low reset.
- ADDR, in, 32: CPU address bus.
- FC, in, 3: CPU function codes.
- RnW, in, 1: read high, write low.
- nAS, in, 1: CPU address strobe.
- nDSACK0, nDSACK1, in, 1 each: sensed bus DSACK lines, active low.
- nDRAM_CS, out, 1: DRAM select, active low.
- nROM_CS, out, 1: ROM select, active low.
- nIO_CS, out, 1: I/O select, active low, for 0xFE000000 to 0xFEFFFFFF.
- nBERR, out, 1: bus error to CPU, active low. Drives an open-drain buffer.
- OVERLAY, out, 1: high while the boot overlay is active.

## Operation
- Address map:
  - DRAM hit: ADDR[31:DRAM_SIZE_LOG2]==0.
  - I/O hit: ADDR[31:24]==8'hFE.
  - ROM hit: ADDR[31:24]==8'hFF. ROM is mirrored across that 16 MB window.
  - Anything else is unmapped.
- CPU-space cycles (FC==3'b111) never produce a chip select. They are not treated as unmapped, so the watchdog still times them out, which gives a spurious interrupt on an unacknowledged IACK.
- Boot overlay:
  - OVERLAY is set by reset.
  - While OVERLAY=1, a read that hits the DRAM window selects ROM instead of DRAM. Writes to the DRAM window still select DRAM.
  - OVERLAY clears on the first cycle that selects ROM through a ROM-window hit, at the edge where that select asserts. It stays 0 until the next reset.
- State machine, 2-bit:
  - IDLE: wait for nAS sampled low.
    - Mapped address or CPU space: assert the decoded select, clear the counter, go to ACTIVE.
    - Unmapped address: assert nBERR, go to BERR.
  - ACTIVE: the select is held and the counter increments each edge.
    - nDSACK0 or nDSACK1 sampled low: freeze the counter, go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 with no DSACK: assert nBERR, go to BERR.
    - nAS sampled high: deassert the select, go to IDLE.
  - DONE: select held, no bus error possible. nAS sampled high: deassert the select, go to IDLE.
  - BERR: nBERR held low and the select held. nAS sampled high: release nBERR and the select, go to IDLE.
- Counter is 10 bits wide and saturates. It never wraps.

## Timing
- Reset values: nDRAM_CS=1, nROM_CS=1, nIO_CS=1, nBERR=1, OVERLAY=1, state IDLE, counter 0.
- Reset is asynchronous. Reset mid-cycle deasserts every output immediately, with no handshake.
- All outputs are registered.
  - Select latency: asserts at the first rising edge where nAS is sampled low. This is one edge ahead of the DRAM controller sampling nCS.
  - Deassertion: at the edge where nAS is sampled high.
- Unmapped cycle: nBERR falls at the same edge a select would have asserted, 1 clock after nAS sampled low.
- Watchdog: nBERR falls TIMEOUT_CYCLES edges after the select edge.
- Simultaneous DSACK and timeout on the same edge: DSACK wins, no bus error.
- nAS high on the same edge as a timeout: go to IDLE, no bus error.
- Back-to-back cycles: one IDLE edge is guaranteed between cycles, because nAS must be sampled high first.
- ADDR, FC and RnW are sampled only on the IDLE→active edge. They are ignored afterwards in the cycle.

## Test plan
- Reset then read ADDR=0x00000000 -> nROM_CS low 1 edge after nAS low, nDRAM_CS stays 1, OVERLAY=1. Write to 0x00000000 -> nDRAM_CS low.
- Read 0xFF000004 during overlay -> nROM_CS low, OVERLAY falls at the same edge. A later read of 0x00000000 -> nDRAM_CS low.
- Default parameters, read 0x00001000, DSACK asserted 6 edges later -> nDRAM_CS low until nAS high, nBERR stays 1. Then read 0x10000000 (unmapped) -> nBERR low 1 edge after nAS low, released when nAS goes high.
- Read 0xFE000010 with no DSACK -> nIO_CS low, nBERR low exactly 250 edges after the select edge. Repeat with DSACK arriving on edge 250 -> no bus error.
- FC=7 cycle at 0xFFFFFFF0 with no DSACK -> no select asserted, nBERR after 250 edges.
- nRST pulsed low mid-ACTIVE -> all selects and nBERR go to 1 immediately and OVERLAY=1. After release, the next cycle decodes normally.
